kavsak_kontrol: RTL and testbench

KAVSAK_KONTROL -- requirements
Module: kavsak_kontrol

---
 rtl/kavsak_pkg.sv | 38 +++
 rtl/kavsak_kontrol_saniye_bolucu.sv | 36 +++
 rtl/kavsak_kontrol.sv | 172 +++++++++++++++++
 tb/tb_kavsak_kontrol.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/kavsak_pkg.sv
// Shared types and default timing constants for the intersection controller.
// Holds the state encoding, the lamp-group payload and width helpers.
package kavsak_pkg;

    // State codes are visible on the durum port, so the encoding is fixed.
    typedef enum logic [2:0] {
        TEMIZ_A   = 3'd0,
        ANA_YESIL = 3'd1,
        ANA_SARI  = 3'd2,
        TEMIZ_B   = 3'd3,
        YAN_YESIL = 3'd4,
        YAN_SARI  = 3'd5,
        FLASH     = 3'd6
    } durum_t;

    // One road's lamp group.
    typedef struct packed {
        logic kirmizi;
        logic sari;
        logic yesil;
    } lamba_t;

    localparam int unsigned VARS_PRESCALE       = 50_000_000;
    localparam int unsigned VARS_TEMIZ_SURE     = 2;
    localparam int unsigned VARS_SARI_SURE      = 3;
    localparam int unsigned VARS_ANA_YESIL_MIN  = 20;
    localparam int unsigned VARS_YAN_YESIL_SURE = 10;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned genislik(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned maks(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kavsak_kontrol_saniye_bolucu.sv
// Free-running prescaler producing the timing tick.
// Ports: clk, rst_n (async, active-low), tick (high for one clk while the
// count sits at PRESCALE-1).
module saniye_bolucu
    import kavsak_pkg::*;
#(
    parameter int unsigned PRESCALE = VARS_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = genislik(PRESCALE);
    localparam logic [CW-1:0] SON = CW'(PRESCALE - 1);

    logic [CW-1:0] sayac;
    logic [CW-1:0] sayac_d;

    // Wrap at PRESCALE-1.
    always_comb begin
        sayac_d = (sayac == SON) ? '0 : sayac + CW'(1);
    end

    // tick is registered against the next count so it coincides with sayac==SON.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sayac <= '0;
            tick  <= 1'(PRESCALE == 1);
        end else begin
            sayac <= sayac_d;
            tick  <= (sayac_d == SON);
        end
    end

endmodule

// File: rtl/kavsak_kontrol.sv
// Two-road intersection controller: main road green until a side-road or
// pedestrian request has been seen after the minimum green, then a timed
// side-road cycle with all-red clearances; maintenance forces yellow flash.
// Ports: clk, rst_n (async, active-low); yan_sensor, yaya_buton, bakim in;
// ana_* / yan_* lamps, yaya_gec and durum (state code) out, all registered.
module kavsak_kontrol
    import kavsak_pkg::*;
#(
    parameter int unsigned PRESCALE       = VARS_PRESCALE,
    parameter int unsigned TEMIZ_SURE     = VARS_TEMIZ_SURE,
    parameter int unsigned SARI_SURE      = VARS_SARI_SURE,
    parameter int unsigned ANA_YESIL_MIN  = VARS_ANA_YESIL_MIN,
    parameter int unsigned YAN_YESIL_SURE = VARS_YAN_YESIL_SURE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       yan_sensor,
    input  logic       yaya_buton,
    input  logic       bakim,
    output logic       ana_kirmizi,
    output logic       ana_sari,
    output logic       ana_yesil,
    output logic       yan_kirmizi,
    output logic       yan_sari,
    output logic       yan_yesil,
    output logic       yaya_gec,
    output logic [2:0] durum
);

    localparam int unsigned MAKS_SURE = maks(maks(TEMIZ_SURE, SARI_SURE),
                                             maks(ANA_YESIL_MIN, YAN_YESIL_SURE));
    localparam int unsigned TW = genislik(MAKS_SURE);

    logic          tick;
    durum_t        durum_q, durum_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          yan_req_q, yan_req_d;
    logic          yaya_req_q, yaya_req_d;
    logic          flas_q, flas_d;
    lamba_t        ana_d, yan_d;
    logic          yaya_d;

    saniye_bolucu #(
        .PRESCALE (PRESCALE)
    ) u_bolucu (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Timer value loaded on entry to a state (duration - 1).
    function automatic logic [TW-1:0] sure_yukle(input durum_t s);
        case (s)
            TEMIZ_A, TEMIZ_B:   return TW'(TEMIZ_SURE - 1);
            ANA_YESIL:          return TW'(ANA_YESIL_MIN - 1);
            ANA_SARI, YAN_SARI: return TW'(SARI_SURE - 1);
            YAN_YESIL:          return TW'(YAN_YESIL_SURE - 1);
            default:            return '0;
        endcase
    endfunction

    // Successor of each timed state.
    function automatic durum_t sonraki(input durum_t s);
        case (s)
            TEMIZ_A:   return ANA_YESIL;
            ANA_YESIL: return ANA_SARI;
            ANA_SARI:  return TEMIZ_B;
            TEMIZ_B:   return YAN_YESIL;
            YAN_YESIL: return YAN_SARI;
            default:   return TEMIZ_A;
        endcase
    endfunction

    // Next-state, timer, request latches, flash phase and lamp decode.
    always_comb begin
        durum_d    = durum_q;
        timer_d    = timer_q;
        yan_req_d  = yan_req_q | yan_sensor;
        yaya_req_d = yaya_req_q | yaya_buton;
        flas_d     = flas_q;
        ana_d      = '{kirmizi: 1'b1, sari: 1'b0, yesil: 1'b0};
        yan_d      = '{kirmizi: 1'b1, sari: 1'b0, yesil: 1'b0};
        yaya_d     = 1'b0;

        case (durum_q)
            // Timer saturates at 0; leaves only once a request is latched.
            ANA_YESIL: begin
                if (tick) begin
                    if (timer_q == '0) begin
                        if (yan_req_q || yaya_req_q) durum_d = ANA_SARI;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            FLASH: begin
                if (tick) flas_d = ~flas_q;
                if (!bakim) durum_d = TEMIZ_A;
            end
            default: begin
                if (tick) begin
                    if (timer_q == '0) durum_d = sonraki(durum_q);
                    else               timer_d = timer_q - TW'(1);
                end
            end
        endcase

        if (bakim) durum_d = FLASH;

        if (durum_d != durum_q) timer_d = sure_yukle(durum_d);

        // Flash always starts lit; outside FLASH the phase rests at 0.
        if (durum_d != FLASH)      flas_d = 1'b0;
        else if (durum_q != FLASH) flas_d = 1'b1;

        // Requests are not sampled during side green and are served on its entry.
        if (durum_q == YAN_YESIL || durum_d == YAN_YESIL ||
            durum_q == FLASH     || durum_d == FLASH) begin
            yan_req_d  = 1'b0;
            yaya_req_d = 1'b0;
        end

        case (durum_d)
            ANA_YESIL: ana_d = '{kirmizi: 1'b0, sari: 1'b0, yesil: 1'b1};
            ANA_SARI:  ana_d = '{kirmizi: 1'b0, sari: 1'b1, yesil: 1'b0};
            YAN_YESIL: begin
                yan_d  = '{kirmizi: 1'b0, sari: 1'b0, yesil: 1'b1};
                yaya_d = 1'b1;
            end
            YAN_SARI:  yan_d = '{kirmizi: 1'b0, sari: 1'b1, yesil: 1'b0};
            FLASH: begin
                ana_d = '{kirmizi: 1'b0, sari: flas_d, yesil: 1'b0};
                yan_d = '{kirmizi: 1'b0, sari: flas_d, yesil: 1'b0};
            end
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q     <= TEMIZ_A;
            timer_q     <= TW'(TEMIZ_SURE - 1);
            yan_req_q   <= 1'b0;
            yaya_req_q  <= 1'b0;
            flas_q      <= 1'b0;
            ana_kirmizi <= 1'b1;
            ana_sari    <= 1'b0;
            ana_yesil   <= 1'b0;
            yan_kirmizi <= 1'b1;
            yan_sari    <= 1'b0;
            yan_yesil   <= 1'b0;
            yaya_gec    <= 1'b0;
            durum       <= 3'd0;
        end else begin
            durum_q     <= durum_d;
            timer_q     <= timer_d;
            yan_req_q   <= yan_req_d;
            yaya_req_q  <= yaya_req_d;
            flas_q      <= flas_d;
            ana_kirmizi <= ana_d.kirmizi;
            ana_sari    <= ana_d.sari;
            ana_yesil   <= ana_d.yesil;
            yan_kirmizi <= yan_d.kirmizi;
            yan_sari    <= yan_d.sari;
            yan_yesil   <= yan_d.yesil;
            yaya_gec    <= yaya_d;
            durum       <= durum_d;
        end
    end

endmodule

// File: tb/tb_kavsak_kontrol.sv
// Scoreboard bench for kavsak_kontrol with a short tick (PRESCALE=4).
// Stimulus pushes the expected per-cycle state/flash phase; a monitor pops
// one entry per falling edge and checks durum, lamps and safety invariants.
module tb_kavsak_kontrol;

    logic       clk;
    logic       rst_n;
    logic       yan_sensor;
    logic       yaya_buton;
    logic       bakim;
    logic       ana_kirmizi, ana_sari, ana_yesil;
    logic       yan_kirmizi, yan_sari, yan_yesil;
    logic       yaya_gec;
    logic [2:0] durum;

    kavsak_kontrol #(
        .PRESCALE       (4),
        .TEMIZ_SURE     (2),
        .SARI_SURE      (3),
        .ANA_YESIL_MIN  (5),
        .YAN_YESIL_SURE (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .yan_sensor  (yan_sensor),
        .yaya_buton  (yaya_buton),
        .bakim       (bakim),
        .ana_kirmizi (ana_kirmizi),
        .ana_sari    (ana_sari),
        .ana_yesil   (ana_yesil),
        .yan_kirmizi (yan_kirmizi),
        .yan_sari    (yan_sari),
        .yan_yesil   (yan_yesil),
        .yaya_gec    (yaya_gec),
        .durum       (durum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] d;
        logic       s;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_cyc  = 0;
    int   pe     = -1;

    // Expected {ak,as,ay,yk,ys,yy,yaya_gec} for a state code.
    function automatic logic [6:0] lampalar(input exp_t e);
        case (e.d)
            3'd0:    return 7'b100_100_0;
            3'd1:    return 7'b001_100_0;
            3'd2:    return 7'b010_100_0;
            3'd3:    return 7'b100_100_0;
            3'd4:    return 7'b100_001_1;
            3'd5:    return 7'b100_010_0;
            default: return {1'b0, e.s, 1'b0, 1'b0, e.s, 1'b0, 1'b0};
        endcase
    endfunction

    task automatic push_seg(input logic [2:0] d, input int n, input logic s);
        exp_t e;
        e.d = d;
        e.s = s;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Advance to 2 time units after posedge k (counted from reset release).
    task automatic goto(input int k);
        for (int i = pe; i < k; i++) @(posedge clk);
        #2;
        pe = k;
    endtask

    // Reset (checked once while asserted), then release just after a posedge.
    task automatic start_run();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push_seg(3'd0, 1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        pe = -1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected cycles left, required 0", q.size());
            q.delete();
        end
    endtask

    exp_t       e_m;
    logic [6:0] got_m, req_m;

    // Monitor: one expected entry per falling edge while the queue holds any.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_m   = q.pop_front();
            got_m = {ana_kirmizi, ana_sari, ana_yesil,
                     yan_kirmizi, yan_sari, yan_yesil, yaya_gec};
            req_m = lampalar(e_m);
            n_chk++;
            if (durum !== e_m.d || got_m !== req_m) begin
                n_fail++;
                $display("FAIL cyc %0d: durum=%0d lamps=%b, required durum=%0d lamps=%b",
                         n_cyc, durum, got_m, e_m.d, req_m);
            end
            n_chk++;
            if ((ana_yesil && yan_yesil) ||
                (durum != 3'd6 &&
                 ((32'(ana_kirmizi) + 32'(ana_sari) + 32'(ana_yesil) != 1) ||
                  (32'(yan_kirmizi) + 32'(yan_sari) + 32'(yan_yesil) != 1)))) begin
                n_fail++;
                $display("FAIL safety cyc %0d: lamps=%b, required one lamp per road and one green",
                         n_cyc, got_m);
            end
            n_cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        yan_sensor = 1'b0;
        yaya_buton = 1'b0;
        bakim      = 1'b0;
        repeat (2) @(posedge clk);

        // No requests: all red 8 clk, then main green holds.
        start_run();
        push_seg(3'd0, 8, 1'b0);
        push_seg(3'd1, 200, 1'b0);
        wait_drain();

        // Side request during main green; pedestrian press only in side green.
        start_run();
        push_seg(3'd0, 8, 1'b0);
        push_seg(3'd1, 20, 1'b0);
        push_seg(3'd2, 12, 1'b0);
        push_seg(3'd3, 8, 1'b0);
        push_seg(3'd4, 16, 1'b0);
        push_seg(3'd5, 12, 1'b0);
        push_seg(3'd0, 8, 1'b0);
        push_seg(3'd1, 60, 1'b0);
        goto(8);  yan_sensor = 1'b1;
        goto(9);  yan_sensor = 1'b0;
        goto(46); yaya_buton = 1'b1;
        goto(62); yaya_buton = 1'b0;
        wait_drain();

        // Maintenance during side green, then release.
        start_run();
        push_seg(3'd0, 8, 1'b0);
        push_seg(3'd1, 20, 1'b0);
        push_seg(3'd2, 12, 1'b0);
        push_seg(3'd3, 8, 1'b0);
        push_seg(3'd4, 3, 1'b0);
        push_seg(3'd6, 1, 1'b1);
        push_seg(3'd6, 4, 1'b0);
        push_seg(3'd6, 4, 1'b1);
        push_seg(3'd6, 4, 1'b0);
        push_seg(3'd6, 4, 1'b1);
        push_seg(3'd0, 8, 1'b0);
        push_seg(3'd1, 20, 1'b0);
        goto(8);  yan_sensor = 1'b1;
        goto(9);  yan_sensor = 1'b0;
        goto(49); bakim = 1'b1;
        goto(66); bakim = 0;
        wait_drain();

        // Reset in the middle of main yellow; nothing survives.
        start_run();
        push_seg(3'd0, 8, 1'b0);
        push_seg(3'd1, 20, 1'b0);
        push_seg(3'd2, 5, 1'b0);
        push_seg(3'd0, 1, 1'b0);
        goto(8);  yan_sensor = 1'b1;
        goto(9);  yan_sensor = 1'b0;
        goto(32); rst_n = 1'b0;
        wait_drain();
        start_run();
        push_seg(3'd0, 8, 1'b0);
        push_seg(3'd1, 40, 1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
